// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR addresses, mstatus bit positions, cause codes and the
// trap sequencer state encoding.
package riscv_csr_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  localparam logic [3:0] ExcIllegalInstr = 4'd2;
  localparam logic [3:0] IrqMTimer       = 4'd7;
  localparam logic [3:0] IrqMExternal    = 4'd11;

  typedef enum logic [2:0] {
    StIdle,
    StWMepc,
    StWMcause,
    StWMtval,
    StWMstatus,
    StRMstatus,
    StRedirect
  } seq_state_e;

endpackage

// File: rtl/trap_priority_enc.sv
// Picks the highest-priority trap or return request for the writeback instruction:
// exception, then external interrupt, then timer interrupt, then MRET.
module trap_priority_enc
  import riscv_csr_pkg::*;
(
  input  logic       wb_v,
  input  logic       exc_valid,
  input  logic [3:0] exc_code,
  input  logic       wb_mret,
  input  logic       irq_timer,
  input  logic       irq_external,
  input  logic       mie_mtie,
  input  logic       mie_meie,
  input  logic       mstatus_mie,
  output logic       take_trap,
  output logic       take_mret,
  output logic       is_irq,
  output logic [3:0] code
);

  logic ext_en;
  logic tim_en;

  assign ext_en = irq_external & mie_meie & mstatus_mie;
  assign tim_en = irq_timer & mie_mtie & mstatus_mie;

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    is_irq    = 1'b0;
    code      = 4'd0;
    if (wb_v) begin
      if (exc_valid) begin
        take_trap = 1'b1;
        code      = exc_code;
      end else if (ext_en) begin
        take_trap = 1'b1;
        is_irq    = 1'b1;
        code      = IrqMExternal;
      end else if (tim_en) begin
        take_trap = 1'b1;
        is_irq    = 1'b1;
        code      = IrqMTimer;
      end else if (wb_mret) begin
        take_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return controller: owns the CSR write port while writing
// mepc/mcause/mtval/mstatus, then redirects the PC; otherwise passes CSR writes through.
module trap_sequencer
  import riscv_csr_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter bit          VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_v,
  input  logic [XLEN-1:0] wb_pc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            wb_mret,
  input  logic            irq_timer,
  input  logic            irq_external,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie_reg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            wb_csr_we,
  input  logic [11:0]     wb_csr_addr,
  input  logic [XLEN-1:0] wb_csr_wdata,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            flush,
  output logic            stall,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc
);

  seq_state_e      state_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;

  logic            take_trap;
  logic            take_mret;
  logic            is_irq;
  logic [3:0]      code;
  logic            unused_mie;

  assign unused_mie = ^{mie_reg[XLEN-1:12], mie_reg[10:8], mie_reg[6:0]};

  trap_priority_enc u_prio (
    .wb_v         (wb_v),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .wb_mret      (wb_mret),
    .irq_timer    (irq_timer),
    .irq_external (irq_external),
    .mie_mtie     (mie_reg[7]),
    .mie_meie     (mie_reg[11]),
    .mstatus_mie  (mstatus[MstatusMie]),
    .take_trap    (take_trap),
    .take_mret    (take_mret),
    .is_irq       (is_irq),
    .code         (code)
  );

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r                            = ms;
    r[MstatusMpie]               = ms[MstatusMie];
    r[MstatusMie]                = 1'b0;
    r[MstatusMppHi:MstatusMppLo] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r                            = ms;
    r[MstatusMie]                = ms[MstatusMpie];
    r[MstatusMpie]               = 1'b1;
    r[MstatusMppHi:MstatusMppLo] = 2'b00;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    // Vectored mode offsets interrupts only; exceptions always use the base.
    if (VEC_EN && tvec[1:0] == 2'b01 && cause[XLEN-1]) begin
      base = base + {{(XLEN-6){1'b0}}, cause[3:0], 2'b00};
    end
    return base;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      epc_q       <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      csr_we      <= 1'b0;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      flush       <= 1'b0;
      stall       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pc_redirect <= 1'b0;
          if (take_trap) begin
            state_q   <= StWMepc;
            epc_q     <= wb_pc;
            cause_q   <= {is_irq, {(XLEN-5){1'b0}}, code};
            tval_q    <= is_irq ? '0 : exc_tval;
            csr_we    <= 1'b1;
            csr_addr  <= CsrMepc;
            csr_wdata <= {wb_pc[XLEN-1:2], 2'b00};
            flush     <= 1'b1;
            stall     <= 1'b1;
          end else if (take_mret) begin
            state_q   <= StRMstatus;
            csr_we    <= 1'b1;
            csr_addr  <= CsrMstatus;
            csr_wdata <= mret_mstatus(mstatus);
            flush     <= 1'b1;
            stall     <= 1'b1;
          end else begin
            csr_we <= wb_csr_we;
            flush  <= 1'b0;
            stall  <= 1'b0;
            if (wb_csr_we) begin
              csr_addr  <= wb_csr_addr;
              csr_wdata <= wb_csr_wdata;
            end
          end
        end
        StWMepc: begin
          state_q   <= StWMcause;
          csr_addr  <= CsrMcause;
          csr_wdata <= cause_q;
        end
        StWMcause: begin
          state_q   <= StWMtval;
          csr_addr  <= CsrMtval;
          csr_wdata <= tval_q;
        end
        StWMtval: begin
          state_q   <= StWMstatus;
          csr_addr  <= CsrMstatus;
          csr_wdata <= trap_mstatus(mstatus);
        end
        StWMstatus: begin
          state_q     <= StRedirect;
          csr_we      <= 1'b0;
          pc_redirect <= 1'b1;
          redirect_pc <= trap_target(mtvec, cause_q);
        end
        StRMstatus: begin
          state_q     <= StRedirect;
          csr_we      <= 1'b0;
          pc_redirect <= 1'b1;
          redirect_pc <= mepc;
        end
        StRedirect: begin
          state_q     <= StIdle;
          csr_we      <= 1'b0;
          pc_redirect <= 1'b0;
          flush       <= 1'b0;
          stall       <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench: directed trap/MRET/passthrough scenarios plus randomized
// traffic, compared each cycle against a schedule-based reference model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_v;
  logic [63:0] wb_pc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [63:0] exc_tval;
  logic        wb_mret;
  logic        irq_timer;
  logic        irq_external;
  logic [63:0] mstatus;
  logic [63:0] mie_reg;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic        wb_csr_we;
  logic [11:0] wb_csr_addr;
  logic [63:0] wb_csr_wdata;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        flush;
  logic        stall;
  logic        pc_redirect;
  logic [63:0] redirect_pc;

  always #5 clk = ~clk;

  trap_sequencer #(
    .XLEN   (64),
    .VEC_EN (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_v         (wb_v),
    .wb_pc        (wb_pc),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_tval     (exc_tval),
    .wb_mret      (wb_mret),
    .irq_timer    (irq_timer),
    .irq_external (irq_external),
    .mstatus      (mstatus),
    .mie_reg      (mie_reg),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .wb_csr_we    (wb_csr_we),
    .wb_csr_addr  (wb_csr_addr),
    .wb_csr_wdata (wb_csr_wdata),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .flush        (flush),
    .stall        (stall),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        flush;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
  } rec_t;

  rec_t exp_q[$];
  rec_t exp_r;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic rec_t quiet_rec();
    rec_t r;
    r.we = 1'b0; r.addr = '0; r.wdata = '0;
    r.flush = 1'b0; r.stall = 1'b0; r.redir = 1'b0; r.rpc = '0;
    return r;
  endfunction

  // Whole trap sequence scheduled at once: four writes, redirect, quiet idle cycle.
  task automatic sched_trap(input logic [3:0] code, input logic irq, input logic [63:0] tval);
    rec_t        r;
    logic [63:0] cause;
    logic [63:0] ms;
    logic [63:0] off;
    cause = (64'(irq) << 63) | 64'(code);
    ms    = (mstatus & ~64'h1888) | (64'(mstatus[3]) << 7) | (64'h3 << 11);
    off   = (mtvec[1:0] == 2'b01 && irq) ? 64'(code) * 4 : 64'd0;
    r = quiet_rec();
    r.we = 1'b1; r.flush = 1'b1; r.stall = 1'b1;
    r.addr = 12'h341; r.wdata = wb_pc & ~64'h3; exp_q.push_back(r);
    r.addr = 12'h342; r.wdata = cause;          exp_q.push_back(r);
    r.addr = 12'h343; r.wdata = tval;           exp_q.push_back(r);
    r.addr = 12'h300; r.wdata = ms;             exp_q.push_back(r);
    r.we = 1'b0; r.redir = 1'b1; r.rpc = (mtvec & ~64'h3) + off;
    exp_q.push_back(r);
    exp_q.push_back(quiet_rec());
  endtask

  task automatic sched_mret();
    rec_t r;
    r = quiet_rec();
    r.we = 1'b1; r.flush = 1'b1; r.stall = 1'b1; r.addr = 12'h300;
    r.wdata = (mstatus & ~64'h1888) | (64'(mstatus[7]) << 3) | 64'h80;
    exp_q.push_back(r);
    r.we = 1'b0; r.redir = 1'b1; r.rpc = mepc;
    exp_q.push_back(r);
    exp_q.push_back(quiet_rec());
  endtask

  // Expected outputs for the next cycle given the inputs currently applied.
  task automatic model_step();
    if (reset) begin
      exp_q.delete();
      exp_r = quiet_rec();
    end else begin
      if (exp_q.size() == 0) begin
        if (wb_v && exc_valid) sched_trap(exc_code, 1'b0, exc_tval);
        else if (wb_v && irq_external && mie_reg[11] && mstatus[3]) sched_trap(4'd11, 1'b1, 64'd0);
        else if (wb_v && irq_timer && mie_reg[7] && mstatus[3]) sched_trap(4'd7, 1'b1, 64'd0);
        else if (wb_v && wb_mret) sched_mret();
      end
      if (exp_q.size() != 0) begin
        exp_r = exp_q.pop_front();
      end else begin
        exp_r = quiet_rec();
        exp_r.we = wb_csr_we; exp_r.addr = wb_csr_addr; exp_r.wdata = wb_csr_wdata;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("csr_we", 64'(csr_we), 64'(exp_r.we));
    if (exp_r.we) begin
      chk("csr_addr", 64'(csr_addr), 64'(exp_r.addr));
      chk("csr_wdata", csr_wdata, exp_r.wdata);
    end
    chk("flush", 64'(flush), 64'(exp_r.flush));
    chk("stall", 64'(stall), 64'(exp_r.stall));
    chk("pc_redirect", 64'(pc_redirect), 64'(exp_r.redir));
    if (exp_r.redir) chk("redirect_pc", redirect_pc, exp_r.rpc);
  endtask

  task automatic clear_req();
    wb_v = 1'b0; exc_valid = 1'b0; exc_code = '0; wb_mret = 1'b0;
    irq_timer = 1'b0; irq_external = 1'b0; wb_csr_we = 1'b0;
  endtask

  task automatic randomize_inputs();
    reset        = ($urandom_range(0, 199) == 0);
    wb_v         = ($urandom_range(0, 9) < 8);
    exc_valid    = ($urandom_range(0, 19) == 0);
    exc_code     = 4'($urandom);
    wb_mret      = ($urandom_range(0, 19) == 0);
    irq_timer    = ($urandom_range(0, 9) == 0);
    irq_external = ($urandom_range(0, 14) == 0);
    wb_pc        = {$urandom, $urandom};
    exc_tval     = {$urandom, $urandom};
    wb_csr_we    = 1'($urandom);
    wb_csr_addr  = 12'($urandom);
    wb_csr_wdata = {$urandom, $urandom};
    // CSR-file view stays stable while a sequence is in flight.
    if (exp_q.size() == 0) begin
      mstatus = {$urandom, $urandom};
      mie_reg = {$urandom, $urandom};
      mtvec   = {$urandom, $urandom};
      mepc    = {$urandom, $urandom};
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_req();
    wb_pc = '0; exc_tval = '0; mstatus = '0; mie_reg = '0; mtvec = '0; mepc = '0;
    wb_csr_addr = '0; wb_csr_wdata = '0;
    step();
    step();
    chk("reset_csr_we", 64'(csr_we), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_redirect_pc", redirect_pc, 64'd0);
    reset = 1'b0;

    // Illegal instruction
    mstatus = 64'h8; mtvec = 64'h8000_0100;
    wb_v = 1'b1; exc_valid = 1'b1; exc_code = 4'd2;
    wb_pc = 64'h8000_0010; exc_tval = 64'h13;
    step();
    chk("ill_mepc_addr", 64'(csr_addr), 64'h341);
    chk("ill_mepc_data", csr_wdata, 64'h8000_0010);
    clear_req();
    step(); chk("ill_mcause", csr_wdata, 64'd2);
    step(); chk("ill_mtval", csr_wdata, 64'h13);
    step(); chk("ill_mstatus", csr_wdata, 64'h1880);
    step(); chk("ill_redirect_pc", redirect_pc, 64'h8000_0100);
    step(); chk("ill_idle_stall", 64'(stall), 64'd0);

    // Vectored timer interrupt
    mie_reg = 64'h80; mtvec = 64'h8000_0101;
    wb_v = 1'b1; irq_timer = 1'b1;
    step();
    clear_req();
    step(); chk("tmr_mcause", csr_wdata, 64'h8000_0000_0000_0007);
    step(); chk("tmr_mtval", csr_wdata, 64'd0);
    step();
    step(); chk("tmr_redirect_pc", redirect_pc, 64'h8000_011C);
    step();

    // External and timer together
    mie_reg = 64'h880; wb_v = 1'b1; irq_timer = 1'b1; irq_external = 1'b1;
    step();
    clear_req();
    step(); chk("ext_mcause", csr_wdata, 64'h8000_0000_0000_000B);
    repeat (4) step();

    // Globally masked: passthrough continues
    mstatus = 64'h0; wb_v = 1'b1; irq_timer = 1'b1; irq_external = 1'b1;
    wb_csr_we = 1'b1; wb_csr_addr = 12'h340; wb_csr_wdata = 64'hABCD;
    step();
    chk("pass_we", 64'(csr_we), 64'd1);
    chk("pass_addr", 64'(csr_addr), 64'h340);
    chk("pass_data", csr_wdata, 64'hABCD);
    clear_req();
    step();

    // MRET
    mstatus = 64'h80; mepc = 64'h8000_0044; wb_v = 1'b1; wb_mret = 1'b1;
    step();
    chk("mret_addr", 64'(csr_addr), 64'h300);
    chk("mret_mstatus", csr_wdata, 64'h88);
    clear_req();
    step(); chk("mret_redirect_pc", redirect_pc, 64'h8000_0044);
    step(); chk("mret_idle_redirect", 64'(pc_redirect), 64'd0);

    // Exception collides with an instruction CSR write
    mstatus = 64'h0; wb_v = 1'b1; exc_valid = 1'b1; exc_code = 4'd5;
    wb_csr_we = 1'b1; wb_csr_addr = 12'h340; wb_csr_wdata = 64'h1234;
    step(); chk("coll_addr", 64'(csr_addr), 64'h341);
    clear_req();
    repeat (5) step();

    // Reset during W_MCAUSE
    wb_v = 1'b1; exc_valid = 1'b1; exc_code = 4'd4;
    step();
    clear_req();
    step(); chk("rst_mcause_addr", 64'(csr_addr), 64'h342);
    reset = 1'b1;
    step();
    chk("rst_mid_we", 64'(csr_we), 64'd0);
    chk("rst_mid_addr", 64'(csr_addr), 64'd0);
    chk("rst_mid_flush", 64'(flush), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_write", 64'(csr_we), 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      randomize_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap and return controller at the writeback stage.
- Detects a retiring exception, a pending interrupt, or an MRET, and owns the single CSR write port during the trap or return. It writes mepc, mcause, mtval and mstatus one per cycle, holds the pipeline flushed, then redirects the PC.
- When idle, it arbitrates the CSR write port in favour of ordinary CSR instructions from writeback.

Parameters:
- XLEN, 64, datapath width.
- VEC_EN, 1, honour vectored mtvec mode (MTVEC[1:0]==01) for interrupts; 0 forces direct mode.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, synchronous, active-high.
- WB_V  in  1  valid instruction in writeback.
- WB_PC  in  64  PC of writeback instruction.
- EXC_VALID  in  1  synchronous exception on the writeback instruction.
- EXC_CODE  in  4  exception cause code.
- EXC_TVAL  in  64  trap value (bad address or IR).
- WB_MRET  in  1  writeback instruction is MRET.
- IRQ_TIMER  in  1  machine timer pending, level.
- IRQ_EXTERNAL  in  1  machine external pending, level.
- MSTATUS  in  64  current mstatus from CSR file.
- MIE_REG  in  64  current mie.
- MTVEC  in  64  current mtvec.
- MEPC  in  64  current mepc.
- WB_CSR_WE  in  1  instruction CSR write request.
- WB_CSR_ADDR  in  12  instruction CSR address.
- WB_CSR_WDATA  in  64  instruction CSR data.
- CSR_WE  out  1  CSR file write enable.
- CSR_ADDR  out  12  CSR file write address.
- CSR_WDATA  out  64  CSR file write data.
- FLUSH  out  1  kill all younger stages.
- STALL  out  1  freeze fetch through writeback.
- PC_REDIRECT  out  1  one-cycle PC load strobe.
- REDIRECT_PC  out  64  new PC.

Behaviour:
- All outputs are registered. On RESET: state IDLE, every output 0, latched cause/epc/tval cleared.
- RESET mid-sequence abandons it with no further CSR writes.

Trigger evaluation (IDLE only, qualified by WB_V), priority high to low:
- EXC_VALID.
- External interrupt: IRQ_EXTERNAL & MIE_REG[11] & MSTATUS[3], code 11.
- Timer interrupt: IRQ_TIMER & MIE_REG[7] & MSTATUS[3], code 7.
- WB_MRET.

On a trap trigger at cycle T:
- Latch epc = WB_PC.
- Latch cause = {interrupt bit at [63], zero-extended code}.
- Latch tval = EXC_TVAL for an exception, 0 for an interrupt.
- The writeback instruction does not commit. Its WB_CSR_WE is dropped.

Trap states (STALL=1 and FLUSH=1 from T+1 through REDIRECT inclusive):
- T+1 W_MEPC: CSR_WE=1, addr 0x341, data epc with bits [1:0] forced to 0.
- T+2 W_MCAUSE: addr 0x342, data cause.
- T+3 W_MTVAL: addr 0x343, data tval.
- T+4 W_MSTATUS: addr 0x300, data MSTATUS with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=11.
- T+5 REDIRECT: CSR_WE=0, PC_REDIRECT=1.
  - REDIRECT_PC = {MTVEC[63:2],2'b00}.
  - If VEC_EN, MTVEC[1:0]==01 and this is an interrupt, add 4*code.
- T+6: back in IDLE, all strobes 0.

On an MRET trigger at T (MRET commits; no other CSR write that cycle):
- T+1 R_MSTATUS: addr 0x300, data MSTATUS with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=00. STALL=1, FLUSH=1.
- T+2 REDIRECT: REDIRECT_PC = MEPC, PC_REDIRECT=1, STALL=1, FLUSH=1.
- T+3: IDLE.

IDLE with no trigger:
- CSR_WE, CSR_ADDR and CSR_WDATA register WB_CSR_WE, WB_CSR_ADDR and WB_CSR_WDATA.
- When WB_CSR_WE is 0, CSR_ADDR and CSR_WDATA hold their previous values.
- Latency is one cycle.

Boundary conditions:
- WB_V=0: no trigger. Pending interrupts wait.
- Interrupt or exception inputs arriving mid-sequence are ignored. They are re-evaluated in IDLE; MIE is cleared by then, so interrupts stay masked.
- The sequencer never asserts back-to-back triggers: the earliest next trigger is the cycle after the return to IDLE.
- Trap and WB_CSR_WE in the same cycle: the trap wins and the instruction write is dropped.
- EXC_VALID and WB_MRET together: treated as an exception.

Decomposition:
- Package riscv_csr_pkg:
  - CSR address constants (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343).
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
  - Cause codes.
  - Sequencer state enum.
- One natural combinational sub-module: trap_priority_enc. It takes the exception, IRQ, enable and MRET inputs and produces take_trap, take_mret, is_irq and code[3:0].

Test Plan:
- Illegal instruction: WB_V=1, EXC_VALID=1, code 2, WB_PC=0x8000_0010, EXC_TVAL=0x0000_0013, MTVEC=0x8000_0100.
  - Writes at T+1..T+4: 0x341 gets 0x8000_0010; 0x342 gets 2; 0x343 gets 0x13; 0x300 gets MIE 0, MPIE old MIE, MPP 3.
  - T+5: PC_REDIRECT=1, REDIRECT_PC=0x8000_0100.
- Vectored timer interrupt: MSTATUS[3]=1, MIE_REG[7]=1, IRQ_TIMER=1, MTVEC=0x8000_0101.
  - mcause=0x8000_0000_0000_0007, mtval=0.
  - REDIRECT_PC=0x8000_011C.
- External and timer pending together:
  - mcause code 11.
  - With MSTATUS[3]=0, no trap at all and passthrough continues.
- MRET with MEPC=0x8000_0044 and MSTATUS[7]=1:
  - T+1: write 0x300 with MIE=1, MPIE=1, MPP=0.
  - T+2: REDIRECT_PC=0x8000_0044.
  - T+3: IDLE.
- Passthrough and collision:
  - WB_CSR_WE=1, addr 0x340, data 0xABCD with no trigger: appears on CSR_* one cycle later.
  - Same request together with EXC_VALID: the 0x340 write is never issued.
- RESET asserted at W_MCAUSE: next cycle all outputs 0, state IDLE, no 0x343 or 0x300 write ever issued.
